// File: rtl/seg_scan_driver_if.sv
// ----------------------------------------------------------------
// seg_scan_driver_if : count input and display pins bundle, rev 1.0
// ----------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface seg_scan_driver_if;
  logic [7:0] num;
  logic       num_vld;
  logic       busy;
  logic [7:0] seg;
  logic [1:0] an;

  modport master (output num, output num_vld, input busy, input seg, input an);
  modport slave  (input num, input num_vld, output busy, output seg, output an);
endinterface

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// ----------------------------------------------------------------
// seg_scan_driver : shift-add-3 BCD converter and 2-digit scan, rev 1.0
// ----------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module seg_scan_driver #(
  parameter int SCAN_DIV = 50000,
  parameter bit LZB      = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  seg_scan_driver_if.slave   bus_if
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // Digit code 4'hA in a display register stands for the overflow dash.
  localparam logic [3:0] DIG_DASH  = 4'hA;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  state_t        state_q, state_d;
  logic [15:0]   sr_q, sr_d;
  logic [2:0]    step_q, step_d;
  logic          ovf_q, ovf_d;
  logic          pend_q, pend_d;
  logic [7:0]    pend_num_q, pend_num_d;
  logic          busy_q, busy_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [CW-1:0] scan_q, scan_d;
  logic          sel_q, sel_d;
  logic [7:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;

  logic [15:0]   w_adj;
  logic [15:0]   w_shift;
  logic          w_load;
  logic [7:0]    w_load_val;
  logic [7:0]    w_tens_seg;
  logic [7:0]    w_ones_seg;

  function automatic logic [7:0] enc7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      DIG_DASH: s = SEG_DASH;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    w_adj = sr_q;
    if (sr_q[15:12] >= 4'd5) w_adj[15:12] = sr_q[15:12] + 4'd3;
    if (sr_q[11:8]  >= 4'd5) w_adj[11:8]  = sr_q[11:8]  + 4'd3;
    w_shift = {w_adj[14:0], 1'b0};
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    step_d     = step_q;
    ovf_d      = ovf_q;
    pend_d     = pend_q;
    pend_num_d = pend_num_q;
    busy_d     = busy_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    w_load     = 1'b0;
    w_load_val = bus_if.num;

    unique case (state_q)
      IDLE: begin
        if (bus_if.num_vld) w_load = 1'b1;
      end
      CONV: begin
        sr_d   = w_shift;
        step_d = step_q + 3'd1;
        if (step_q == 3'd7) begin
          tens_d = ovf_q ? DIG_DASH : w_shift[15:12];
          ones_d = ovf_q ? DIG_DASH : w_shift[11:8];
          // A strobe on the completion edge is newer than anything pending.
          if (bus_if.num_vld) begin
            w_load = 1'b1;
            pend_d = 1'b0;
          end else if (pend_q) begin
            w_load     = 1'b1;
            w_load_val = pend_num_q;
            pend_d     = 1'b0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else if (bus_if.num_vld) begin
          pend_d     = 1'b1;
          pend_num_d = bus_if.num;
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_load) begin
      sr_d    = {8'h00, w_load_val};
      ovf_d   = (w_load_val > 8'd99);
      step_d  = 3'd0;
      busy_d  = 1'b1;
      state_d = CONV;
    end
  end

  always_comb begin
    if (tens_q == DIG_DASH)          w_tens_seg = SEG_DASH;
    else if (LZB && tens_q == 4'd0)  w_tens_seg = SEG_BLANK;
    else                             w_tens_seg = enc7(tens_q);
    w_ones_seg = enc7(ones_q);

    if (scan_q == CW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      sel_d  = ~sel_q;
    end else begin
      scan_d = scan_q + CW'(1);
      sel_d  = sel_q;
    end

    an_d  = sel_q ? 2'b01 : 2'b10;
    seg_d = sel_q ? w_tens_seg : w_ones_seg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      step_q     <= '0;
      ovf_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_num_q <= '0;
      busy_q     <= 1'b0;
      tens_q     <= '0;
      ones_q     <= '0;
      scan_q     <= '0;
      sel_q      <= 1'b0;
      seg_q      <= SEG_BLANK;
      an_q       <= 2'b11;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      step_q     <= step_d;
      ovf_q      <= ovf_d;
      pend_q     <= pend_d;
      pend_num_q <= pend_num_d;
      busy_q     <= busy_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      scan_q     <= scan_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign bus_if.busy = busy_q;
  assign bus_if.seg  = seg_q;
  assign bus_if.an   = an_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// ----------------------------------------------------------------
// tb_seg_scan_driver : scoreboard bench for two LZB variants, rev 1.0
// ----------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_seg_scan_driver;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] num_s = 8'd0;
  logic       vld_s = 1'b0;

  always #5 clk = ~clk;

  seg_scan_driver_if if1 ();
  seg_scan_driver_if if0 ();

  assign if1.num     = num_s;
  assign if1.num_vld = vld_s;
  assign if0.num     = num_s;
  assign if0.num_vld = vld_s;

  seg_scan_driver #(.SCAN_DIV(D), .LZB(1'b1)) dut1 (.clk(clk), .rst(rst), .bus_if(if1.slave));
  seg_scan_driver #(.SCAN_DIV(D), .LZB(1'b0)) dut0 (.clk(clk), .rst(rst), .bus_if(if0.slave));

  typedef struct {
    logic       busy;
    logic [7:0] seg1;
    logic [7:0] seg0;
    logic [1:0] an;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [7:0] seg_tab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  function automatic logic [7:0] ones_exp(input int v);
    if (v > 99) return 8'hBF;
    return seg_tab[v % 10];
  endfunction

  function automatic logic [7:0] tens_exp(input int v, input bit lzb);
    if (v > 99) return 8'hBF;
    if (lzb && (v / 10) == 0) return 8'hFF;
    return seg_tab[v / 10];
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %02h expected %02h", name, $time, act, exp);
    end
  endtask

  // Reference model: a timeline of conversions, each finishing 8 edges after it starts.
  initial begin : model
    int  t = 0, k = 0, disp = 0, conv_val = 0, conv_end = 0, pend_val = 0;
    bit  active = 0, pend = 0, sel;
    exp_t e;
    forever begin
      @(posedge clk);
      t++;
      if (rst) begin
        active = 0; pend = 0; disp = 0; k = 0;
        e.busy = 1'b0; e.seg1 = 8'hFF; e.seg0 = 8'hFF; e.an = 2'b11;
      end else begin
        k++;
        sel  = (((k - 1) / D) % 2) == 1;
        e.an   = sel ? 2'b01 : 2'b10;
        e.seg1 = sel ? tens_exp(disp, 1'b1) : ones_exp(disp);
        e.seg0 = sel ? tens_exp(disp, 1'b0) : ones_exp(disp);
        if (active && t == conv_end) begin
          disp = conv_val;
          if (vld_s) begin
            conv_val = int'(num_s); conv_end = t + 8; pend = 0;
          end else if (pend) begin
            conv_val = pend_val; conv_end = t + 8; pend = 0;
          end else begin
            active = 0;
          end
        end else if (active) begin
          if (vld_s) begin pend = 1; pend_val = int'(num_s); end
        end else if (vld_s) begin
          active = 1; conv_val = int'(num_s); conv_end = t + 8;
        end
        e.busy = active;
      end
      sbq.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL scoreboard_empty @%0t: got 0 entries expected 1", $time);
      end else begin
        e = sbq.pop_front();
        chk("busy_lzb1", {7'd0, if1.busy}, {7'd0, e.busy});
        chk("busy_lzb0", {7'd0, if0.busy}, {7'd0, e.busy});
        chk("an_lzb1",   {6'd0, if1.an},   {6'd0, e.an});
        chk("an_lzb0",   {6'd0, if0.an},   {6'd0, e.an});
        chk("seg_lzb1",  if1.seg, e.seg1);
        chk("seg_lzb0",  if0.seg, e.seg0);
      end
    end
  end

  task automatic cyc(input bit r, input bit v, input logic [7:0] n);
    @(negedge clk);
    rst = r; vld_s = v; num_s = n;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 8'd0);
  endtask

  initial begin : stim
    repeat (3) cyc(1'b1, 1'b0, 8'd0);
    idle(12);
    cyc(1'b0, 1'b1, 8'd29);  idle(20);
    cyc(1'b0, 1'b1, 8'd7);   idle(20);
    cyc(1'b0, 1'b1, 8'd150); idle(20);
    // 14 at E0, 3 at E3, 9 at E5: the 9 replaces the 3 while pending.
    cyc(1'b0, 1'b1, 8'd14);  idle(2);
    cyc(1'b0, 1'b1, 8'd3);   idle(1);
    cyc(1'b0, 1'b1, 8'd9);   idle(30);
    cyc(1'b0, 1'b1, 8'd42);  idle(7);
    cyc(1'b0, 1'b1, 8'd63);  idle(20);
    cyc(1'b0, 1'b1, 8'd88);  idle(3);
    cyc(1'b1, 1'b0, 8'd0);   idle(20);
    for (int i = 0; i < 3000; i++) begin
      bit         r, v;
      logic [7:0] n;
      r = ($urandom_range(0, 399) == 0);
      v = !r && ($urandom_range(0, 5) == 0);
      n = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 99));
      cyc(r, v, n);
    end
    idle(20);
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
